// File: rtl/cursor_controller.sv
// cursor_controller: turns five raw pushbuttons and a pan switch into the
// cursor position, viewport origin and a one-cycle cell-toggle click.
//   clk_in, rst_n_in           : single clock domain, async active-low reset
//   btnu/btnd/btnl/btnr/btnc_in : raw asynchronous buttons
//   pan_in                      : raw switch, 1 = arrows pan the view
//   cursor_x/y_out              : cursor cell on the 2^POS_W torus
//   view_x/y_out                : viewport top-left cell
//   click_out                   : pulse on each debounced btnc press

// Per-button lane: 2-flop synchronizer followed by a stable-state debouncer.
//   raw_in : asynchronous button level
//   db_out : debounced level
module cursor_btn_cond #(
  parameter int DEBOUNCE_CYC = 1_300_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_in,
  output logic db_out
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      db_out <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      // cnt is the run length of samples disagreeing with the stable level
      if (s2 == db_out) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_out <= ~db_out;
        cnt    <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

module cursor_controller #(
  parameter int POS_W         = 8,
  parameter int VIEW_W        = 128,
  parameter int VIEW_H        = 96,
  parameter int DEBOUNCE_CYC  = 1_300_000,
  parameter int REPEAT_DELAY  = 65_000_000,
  parameter int REPEAT_PERIOD = 13_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             btnu_in,
  input  logic             btnd_in,
  input  logic             btnl_in,
  input  logic             btnr_in,
  input  logic             btnc_in,
  input  logic             pan_in,
  output logic [POS_W-1:0] cursor_x_out,
  output logic [POS_W-1:0] cursor_y_out,
  output logic [POS_W-1:0] view_x_out,
  output logic [POS_W-1:0] view_y_out,
  output logic             click_out
);
  localparam int NUM_BTN = 5;
  localparam int B_U = 0, B_D = 1, B_L = 2, B_R = 3, B_C = 4;
  localparam int TMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W = $clog2(TMAX + 1);

  generate
    if (VIEW_W >= (1 << POS_W)) begin : g_bad_view_w
      $error("VIEW_W must be smaller than 2**POS_W");
    end
    if (VIEW_H >= (1 << POS_W)) begin : g_bad_view_h
      $error("VIEW_H must be smaller than 2**POS_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_t;

  logic [NUM_BTN-1:0] raw, db, db_q;
  logic               pan_s1, pan_s;
  st_t                st;
  logic [TMR_W-1:0]   tmr;

  assign raw = {btnc_in, btnr_in, btnl_in, btnd_in, btnu_in};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    cursor_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .raw_in  (raw[i]),
      .db_out  (db[i])
    );
  end

  logic             dir_hi, dir_rise, step;
  logic [POS_W-1:0] sx, sy, cx_n, cy_n, rel_x, rel_y, vx_n, vy_n;

  always_comb begin
    dir_hi   = |db[B_R:B_U];
    dir_rise = |(db[B_R:B_U] & ~db_q[B_R:B_U]);
    step     = dir_hi && (dir_rise ||
               (st == DELAY  && tmr == TMR_W'(REPEAT_DELAY - 1)) ||
               (st == REPEAT && tmr == TMR_W'(REPEAT_PERIOD - 1)));

    // opposing buttons cancel; -1 is the all-ones POS_W value
    sx = '0;
    if (db[B_R] && !db[B_L]) sx = POS_W'(1);
    else if (db[B_L] && !db[B_R]) sx = '1;
    sy = '0;
    if (db[B_D] && !db[B_U]) sy = POS_W'(1);
    else if (db[B_U] && !db[B_D]) sy = '1;

    cx_n  = cursor_x_out + sx;
    cy_n  = cursor_y_out + sy;
    rel_x = cx_n - view_x_out;
    rel_y = cy_n - view_y_out;

    // a single step moves at most one cell, so the cursor can only leave the
    // viewport by one cell on either side; drag the view by the same cell
    vx_n = view_x_out;
    vy_n = view_y_out;
    if (pan_s) begin
      vx_n = view_x_out + sx;
      vy_n = view_y_out + sy;
    end else begin
      if (rel_x == POS_W'(VIEW_W)) vx_n = view_x_out + POS_W'(1);
      else if (rel_x == '1)        vx_n = view_x_out - POS_W'(1);
      if (rel_y == POS_W'(VIEW_H)) vy_n = view_y_out + POS_W'(1);
      else if (rel_y == '1)        vy_n = view_y_out - POS_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pan_s1       <= 1'b0;
      pan_s        <= 1'b0;
      db_q         <= '0;
      st           <= IDLE;
      tmr          <= '0;
      cursor_x_out <= '0;
      cursor_y_out <= '0;
      view_x_out   <= '0;
      view_y_out   <= '0;
      click_out    <= 1'b0;
    end else begin
      pan_s1    <= pan_in;
      pan_s     <= pan_s1;
      db_q      <= db;
      click_out <= db[B_C] & ~db_q[B_C];

      if (!dir_hi) begin
        st  <= IDLE;
        tmr <= '0;
      end else if (dir_rise) begin
        st  <= DELAY;
        tmr <= '0;
      end else begin
        case (st)
          DELAY: begin
            if (tmr == TMR_W'(REPEAT_DELAY - 1)) begin
              st  <= REPEAT;
              tmr <= '0;
            end else tmr <= tmr + 1'b1;
          end
          REPEAT: begin
            if (tmr == TMR_W'(REPEAT_PERIOD - 1)) tmr <= '0;
            else tmr <= tmr + 1'b1;
          end
          default: tmr <= '0;
        endcase
      end

      if (step) begin
        cursor_x_out <= cx_n;
        cursor_y_out <= cy_n;
        view_x_out   <= vx_n;
        view_y_out   <= vy_n;
      end
    end
  end
endmodule

// File: tb/tb_cursor_controller.sv
// tb_cursor_controller: directed scenarios plus randomized button traffic,
// checked every cycle against a history-based behavioural model.
module tb_cursor_controller;
  localparam int PW = 4, VW = 8, VH = 6, DB = 4, RD = 20, RP = 5;
  localparam int M = 1 << PW;
  localparam int MAXC = 16384;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;
  logic btnu_in = 0, btnd_in = 0, btnl_in = 0, btnr_in = 0, btnc_in = 0, pan_in = 0;
  logic [PW-1:0] cursor_x_out, cursor_y_out, view_x_out, view_y_out;
  logic click_out;

  cursor_controller #(
    .POS_W(PW), .VIEW_W(VW), .VIEW_H(VH), .DEBOUNCE_CYC(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .btnu_in(btnu_in), .btnd_in(btnd_in), .btnl_in(btnl_in),
    .btnr_in(btnr_in), .btnc_in(btnc_in), .pan_in(pan_in),
    .cursor_x_out(cursor_x_out), .cursor_y_out(cursor_y_out),
    .view_x_out(view_x_out), .view_y_out(view_y_out),
    .click_out(click_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0, n_fail = 0;
  int e = 20;          // index of the most recent rising clock edge
  int clicks = 0;

  // stimulus registers, applied at each falling edge; bit order {C,R,L,D,U}
  logic [4:0] btn = '0;
  logic       pan = 1'b0;
  logic       rst_v = 1'b0;

  // model: raw samples and debounced levels per edge
  logic [4:0] raw_h [MAXC];
  logic       pan_h [MAXC];
  logic [4:0] mdb   [MAXC];
  int mcx, mcy, mvx, mvy, mclk, anchor;

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_edge();
    logic [4:0] dp, dq;
    bit hi, rise, step, flip;
    int sx, sy, rx, ry;
    if (!rst_n_in) begin
      for (int i = e - 16; i <= e; i++) begin
        raw_h[i] = '0; pan_h[i] = 1'b0; mdb[i] = '0;
      end
      mcx = 0; mcy = 0; mvx = 0; mvy = 0; mclk = 0; anchor = -1;
      return;
    end
    raw_h[e] = btn;
    pan_h[e] = pan;
    dp = mdb[e-1];
    dq = mdb[e-2];
    hi   = |dp[3:0];
    rise = |(dp[3:0] & ~dq[3:0]);
    step = 0;
    // steps: immediately on a press, then RD after it, then every RP
    if (!hi) anchor = -1;
    else if (rise) begin step = 1; anchor = e; end
    else if (anchor >= 0 && e - anchor >= RD && (e - anchor - RD) % RP == 0) step = 1;
    if (step) begin
      sx = int'(dp[3]) - int'(dp[2]);
      sy = int'(dp[1]) - int'(dp[0]);
      mcx = (mcx + sx) & (M - 1);
      mcy = (mcy + sy) & (M - 1);
      if (pan_h[e-2]) begin
        mvx = (mvx + sx) & (M - 1);
        mvy = (mvy + sy) & (M - 1);
      end else begin
        rx = (mcx - mvx) & (M - 1);
        ry = (mcy - mvy) & (M - 1);
        if (rx == VW) mvx = (mvx + 1) & (M - 1);
        else if (rx == M - 1) mvx = (mvx + M - 1) & (M - 1);
        if (ry == VH) mvy = (mvy + 1) & (M - 1);
        else if (ry == M - 1) mvy = (mvy + M - 1) & (M - 1);
      end
    end
    mclk = int'(dp[4] & ~dq[4]);
    // a level is accepted once the last DB raw samples (delayed by the
    // synchronizer) all disagree with the accepted level
    for (int b = 0; b < 5; b++) begin
      flip = 1;
      for (int k = 2; k <= DB + 1; k++)
        if (raw_h[e-k][b] == dp[b]) flip = 0;
      mdb[e][b] = flip ? ~dp[b] : dp[b];
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    {btnc_in, btnr_in, btnl_in, btnd_in, btnu_in} = btn;
    pan_in   = pan;
    rst_n_in = rst_v;
    @(posedge clk_in);
    e++;
    if (e >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", e, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    model_edge();
    #1;
    chk("cursor_x", int'(cursor_x_out), mcx);
    chk("cursor_y", int'(cursor_y_out), mcy);
    chk("view_x",   int'(view_x_out),   mvx);
    chk("view_y",   int'(view_y_out),   mvy);
    chk("click",    int'(click_out),    mclk);
    if (rst_n_in && !pan_h[e-2] && !pan_h[e-3]) begin
      chk("rel_x_in_view", int'(((int'(cursor_x_out) - int'(view_x_out)) & (M - 1)) < VW), 1);
      chk("rel_y_in_view", int'(((int'(cursor_y_out) - int'(view_y_out)) & (M - 1)) < VH), 1);
    end
    if (click_out) clicks++;
  endtask

  // asynchronous assertion mid-cycle, outputs must clear before any edge
  task automatic do_reset();
    rst_n_in = 1'b0;
    rst_v    = 1'b0;
    #1;
    chk("rst_cursor_x", int'(cursor_x_out), 0);
    chk("rst_cursor_y", int'(cursor_y_out), 0);
    chk("rst_view_x",   int'(view_x_out),   0);
    chk("rst_view_y",   int'(view_y_out),   0);
    chk("rst_click",    int'(click_out),    0);
    repeat (3) tick();
    rst_v = 1'b1;
  endtask

  task automatic press(logic [4:0] b, int hold, int rel);
    btn = b;
    repeat (hold) tick();
    btn = '0;
    repeat (rel) tick();
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin raw_h[i] = '0; pan_h[i] = 1'b0; mdb[i] = '0; end
    mcx = 0; mcy = 0; mvx = 0; mvy = 0; mclk = 0; anchor = -1;
    #2;
    do_reset();

    // single press: step lands on edge 6 of the hold
    btn = 5'b01000;
    repeat (6) tick();
    chk("press_before", int'(cursor_x_out), 0);
    tick();
    chk("press_at6", int'(cursor_x_out), 1);
    repeat (3) tick();
    btn = '0;
    repeat (15) tick();
    chk("press_final_x", int'(cursor_x_out), 1);
    chk("press_final_vx", int'(view_x_out), 0);

    // bounce rejection
    do_reset();
    for (int i = 0; i < 15; i++) begin
      btn = (i % 2 == 0) ? 5'b01000 : 5'b00000;
      repeat (2) tick();
    end
    btn = '0;
    repeat (10) tick();
    chk("bounce_x", int'(cursor_x_out), 0);

    // auto-repeat: steps at 6, 26, 31, 36, 41
    do_reset();
    press(5'b01000, 40, 15);
    chk("repeat_x", int'(cursor_x_out), 5);
    chk("repeat_vx", int'(view_x_out), 0);

    // longer hold walks past the right edge and drags the view
    do_reset();
    press(5'b01000, 55, 15);
    chk("follow_x", int'(cursor_x_out), 8);
    chk("follow_vx", int'(view_x_out), 1);

    // wrap left and up from origin
    do_reset();
    press(5'b00100, 10, 12);
    chk("wrapl_x", int'(cursor_x_out), 15);
    chk("wrapl_vx", int'(view_x_out), 15);
    do_reset();
    press(5'b00001, 10, 12);
    chk("wrapu_y", int'(cursor_y_out), 15);
    chk("wrapu_vy", int'(view_y_out), 15);

    // pan, cancellation, diagonal
    do_reset();
    pan = 1'b1;
    repeat (4) tick();
    press(5'b00010, 10, 12);
    chk("pan_vy", int'(view_y_out), 1);
    chk("pan_cy", int'(cursor_y_out), 1);
    pan = 1'b0;
    do_reset();
    press(5'b00011, 30, 12);
    chk("cancel_y", int'(cursor_y_out), 0);
    do_reset();
    press(5'b00101, 10, 12);
    chk("diag_x", int'(cursor_x_out), 15);
    chk("diag_y", int'(cursor_y_out), 15);

    // click: one pulse per press, fresh press after reset mid-hold
    do_reset();
    clicks = 0;
    press(5'b10000, 100, 12);
    chk("click_count", clicks, 1);
    btn = 5'b10000;
    repeat (20) tick();
    do_reset();
    clicks = 0;
    repeat (20) tick();
    btn = '0;
    repeat (10) tick();
    chk("click_after_rst", clicks, 1);

    // randomized traffic
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) pan = ~pan;
      btn = ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom_range(1, 31));
      repeat ($urandom_range(1, 45)) tick();
    end
    btn = '0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
